// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b/66b block alignment. Watches the 2-bit sync header of each
// received block, requests bitslips until alignment is found, declares lock
// after a run of good headers, and drops lock when too many bad headers show
// up inside one monitoring window.
module rx_block_lock #(
  parameter int LOCK_CNT  = 64,
  parameter int GOOD_WIN  = 1024,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [1:0] rx_header,
  input  logic       rx_header_valid,
  output logic       block_lock,
  output logic       bitslip,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] state
);

  // sh_cnt counts both the acquire run and the locked window, so it is sized
  // for whichever of the two limits is larger.
  localparam int SH_MAX = (LOCK_CNT > GOOD_WIN) ? LOCK_CNT : GOOD_WIN;
  localparam int SH_W   = $clog2(SH_MAX) + 1;
  localparam int BAD_W  = $clog2(BAD_MAX) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED    = 2'd1,
    SLIP_HOLD = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SH_W-1:0]    sh_cnt;
  logic [SH_W-1:0]    sh_d;
  logic [BAD_W-1:0]   bad_cnt;
  logic [BAD_W-1:0]   bad_d;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_d;
  logic               slip_d;
  logic [7:0]         loss_d;

  logic               good;
  logic [SH_W-1:0]    sh_inc;
  logic [BAD_W-1:0]   bad_inc;
  logic [WAIT_W-1:0]  wait_inc;
  logic               acquire_hit;
  logic               loss_hit;
  logic               win_hit;
  logic               hold_done;

  // Header classification and threshold detection shared by both comb blocks.
  always_comb begin
    good        = (rx_header == 2'b01) || (rx_header == 2'b10);
    sh_inc      = sh_cnt + SH_W'(1);
    bad_inc     = bad_cnt + (good ? BAD_W'(0) : BAD_W'(1));
    wait_inc    = wait_cnt + WAIT_W'(1);
    acquire_hit = good && (sh_inc == SH_W'(LOCK_CNT));
    loss_hit    = !good && (bad_inc == BAD_W'(BAD_MAX));
    win_hit     = (sh_inc == SH_W'(GOOD_WIN));
    hold_done   = (wait_inc == WAIT_W'(SLIP_WAIT));
  end

  // State register; reset forces UNLOCKED without waiting for a clock edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= UNLOCKED;
    else     state_q <= state_d;
  end

  // Next-state logic; nothing moves on cycles without a valid header.
  always_comb begin
    state_d = state_q;
    if (rx_header_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (!good)            state_d = SLIP_HOLD;
          else if (acquire_hit) state_d = LOCKED;
        end
        LOCKED: begin
          if (loss_hit) state_d = SLIP_HOLD;
        end
        SLIP_HOLD: begin
          if (hold_done) state_d = UNLOCKED;
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // Counter, bitslip and lock-loss next values. Lock loss is tested before the
  // window rollover so a bad header that is also the last in its window wins.
  always_comb begin
    sh_d   = sh_cnt;
    bad_d  = bad_cnt;
    wait_d = wait_cnt;
    slip_d = 1'b0;
    loss_d = lock_loss_cnt;
    if (rx_header_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (!good) begin
            slip_d = 1'b1;
            sh_d   = '0;
            wait_d = '0;
          end else if (acquire_hit) begin
            sh_d  = '0;
            bad_d = '0;
          end else begin
            sh_d = sh_inc;
          end
        end
        LOCKED: begin
          if (loss_hit) begin
            slip_d = 1'b1;
            sh_d   = '0;
            bad_d  = '0;
            wait_d = '0;
            if (lock_loss_cnt != 8'hff) loss_d = lock_loss_cnt + 8'd1;
          end else if (win_hit) begin
            sh_d  = '0;
            bad_d = '0;
          end else begin
            sh_d  = sh_inc;
            bad_d = bad_inc;
          end
        end
        SLIP_HOLD: begin
          if (hold_done) begin
            sh_d   = '0;
            bad_d  = '0;
            wait_d = '0;
          end else begin
            wait_d = wait_inc;
          end
        end
        default: begin
          sh_d   = '0;
          bad_d  = '0;
          wait_d = '0;
        end
      endcase
    end
  end

  // Counter and output registers, all cleared asynchronously by reset.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sh_cnt        <= '0;
      bad_cnt       <= '0;
      wait_cnt      <= '0;
      bitslip       <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sh_cnt        <= sh_d;
      bad_cnt       <= bad_d;
      wait_cnt      <= wait_d;
      bitslip       <= slip_d;
      lock_loss_cnt <= loss_d;
    end
  end

  // Lock status is a decode of the registered state, so reset drops it at once.
  assign block_lock = (state_q == LOCKED);
  assign state      = state_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock: directed scenarios plus random traffic for rx_block_lock,
// checked through an expected-value queue filled by a behavioural model.
module tb_rx_block_lock;

  localparam int LOCK_CNT  = 64;
  localparam int GOOD_WIN  = 1024;
  localparam int BAD_MAX   = 16;
  localparam int SLIP_WAIT = 4;

  logic       CLK;
  logic       rst;
  logic [1:0] rx_header;
  logic       rx_header_valid;
  logic       block_lock;
  logic       bitslip;
  logic [7:0] lock_loss_cnt;
  logic [1:0] dut_state;

  rx_block_lock #(
    .LOCK_CNT (LOCK_CNT),
    .GOOD_WIN (GOOD_WIN),
    .BAD_MAX  (BAD_MAX),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .CLK            (CLK),
    .rst            (rst),
    .rx_header      (rx_header),
    .rx_header_valid(rx_header_valid),
    .block_lock     (block_lock),
    .bitslip        (bitslip),
    .lock_loss_cnt  (lock_loss_cnt),
    .state          (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  // Expected word after each edge: {block_lock, bitslip, lock_loss_cnt}.
  logic [9:0] exp_q[$];
  int vectors   = 0;
  int miscompares = 0;

  // Behavioural reference: lock flag, length of the current good run, headers
  // and bad headers seen in the current locked window, headers still to skip
  // after a slip, and the saturating loss total.
  bit m_locked;
  int m_run;
  int m_win;
  int m_bads;
  int m_skip;
  int m_loss;

  function automatic void model_reset();
    m_locked = 0;
    m_run    = 0;
    m_win    = 0;
    m_bads   = 0;
    m_skip   = 0;
    m_loss   = 0;
  endfunction

  function automatic logic [9:0] model_step(input logic [1:0] h, input logic v);
    bit good;
    bit slip;
    slip = 0;
    good = (h == 2'b01) || (h == 2'b10);
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
        m_run = 0;
      end else if (!m_locked) begin
        if (good) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_locked = 1;
            m_run    = 0;
            m_win    = 0;
            m_bads   = 0;
          end
        end else begin
          slip   = 1;
          m_run  = 0;
          m_skip = SLIP_WAIT;
        end
      end else begin
        m_win++;
        if (!good) m_bads++;
        if (m_bads == BAD_MAX) begin
          m_locked = 0;
          slip     = 1;
          m_loss   = (m_loss < 255) ? m_loss + 1 : 255;
          m_skip   = SLIP_WAIT;
          m_win    = 0;
          m_bads   = 0;
          m_run    = 0;
        end else if (m_win == GOOD_WIN) begin
          m_win  = 0;
          m_bads = 0;
        end
      end
    end
    return {m_locked, slip, 8'(m_loss)};
  endfunction

  // Monitor: one expected word per applied cycle, compared just after the edge.
  always @(posedge CLK) begin
    logic [9:0] exp_w;
    logic [9:0] act_w;
    #1;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act_w = {block_lock, bitslip, lock_loss_cnt};
      vectors++;
      if (act_w !== exp_w) begin
        miscompares++;
        $display("FAIL outputs t=%0t lock/slip/loss got %b/%b/%0d expected %b/%b/%0d",
                 $time, act_w[9], act_w[8], act_w[7:0], exp_w[9], exp_w[8], exp_w[7:0]);
      end
    end
  end

  // Direct checks taken between edges (asynchronous behaviour).
  task automatic check_now(input string name, input logic [9:0] exp_w);
    logic [9:0] act_w;
    act_w = {block_lock, bitslip, lock_loss_cnt};
    vectors++;
    if (act_w !== exp_w) begin
      miscompares++;
      $display("FAIL %s lock/slip/loss got %b/%b/%0d expected %b/%b/%0d",
               name, act_w[9], act_w[8], act_w[7:0], exp_w[9], exp_w[8], exp_w[7:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [1:0] h, input logic v, input logic r);
    @(negedge CLK);
    rst             = r;
    rx_header       = h;
    rx_header_valid = v;
    if (r) begin
      model_reset();
      exp_q.push_back(10'd0);
    end else begin
      exp_q.push_back(model_step(h, v));
    end
  endtask

  function automatic logic [1:0] rand_good();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rand_bad();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic good_n(input int n);
    for (int i = 0; i < n; i++) apply(rand_good(), 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) apply(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst             = 1'b1;
    rx_header       = 2'b00;
    rx_header_valid = 1'b0;
    model_reset();

    // reset: random headers while held in reset
    do_reset(12);
    check_now("reset_hold", 10'd0);

    // acquire: 63 x 01 then 10
    for (int i = 0; i < LOCK_CNT - 1; i++) apply(2'b01, 1'b1, 1'b0);
    apply(2'b10, 1'b1, 1'b0);
    apply(2'b01, 1'b0, 1'b0);

    // slip: 10 good, one 00, four 11, 64 good
    do_reset(2);
    good_n(10);
    apply(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < SLIP_WAIT; i++) apply(2'b11, 1'b1, 1'b0);
    good_n(LOCK_CNT);

    // bad threshold: 15 bad spread through the window, then the 16th
    for (int i = 0; i < BAD_MAX - 1; i++) begin
      good_n($urandom_range(0, 20));
      apply(rand_bad(), 1'b1, 1'b0);
    end
    good_n(5);
    apply(rand_bad(), 1'b1, 1'b0);
    good_n(8);

    // window boundary: 15 bad in window 1 and in window 2 keep lock
    do_reset(2);
    good_n(LOCK_CNT);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < GOOD_WIN; i++)
        apply(((i % 64 == 0) && (i < 64 * (BAD_MAX - 1))) ? rand_bad() : rand_good(), 1'b1, 1'b0);
    good_n(20);

    // window boundary: 16th bad as header 1024 of a window loses lock
    do_reset(2);
    good_n(LOCK_CNT);
    good_n(GOOD_WIN - BAD_MAX);
    for (int i = 0; i < BAD_MAX; i++) apply(rand_bad(), 1'b1, 1'b0);
    good_n(6);

    // reset mid-LOCKED: lock falls without a clock edge, no loss counted
    do_reset(2);
    good_n(LOCK_CNT + 10);
    @(negedge CLK);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset", 10'd0);
    model_reset();
    do_reset(2);

    // saturation: 300 forced lock losses
    for (int k = 0; k < 300; k++) begin
      good_n(LOCK_CNT);
      for (int i = 0; i < BAD_MAX; i++) apply(rand_bad(), 1'b1, 1'b0);
      for (int i = 0; i < SLIP_WAIT; i++) apply(2'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
    apply(2'b01, 1'b0, 1'b0);
    @(negedge CLK);
    check_now("loss_saturated", {1'b0, 1'b0, 8'd255});

    // valid gaps: acquire with random idle cycles in between
    do_reset(2);
    for (int i = 0; i < LOCK_CNT; i++) begin
      while ($urandom_range(0, 2) == 0) apply(2'($urandom_range(0, 3)), 1'b0, 1'b0);
      apply(rand_good(), 1'b1, 1'b0);
    end
    apply(2'b00, 1'b0, 1'b0);

    // random traffic: gaps everywhere, bursts of bad headers now and then
    for (int i = 0; i < 4000; i++) begin
      logic v;
      logic [1:0] h;
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 99) < 3) ? rand_bad() : rand_good();
      apply(h, v, 1'b0);
    end

    // drain the scoreboard with a bounded wait
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain %0d expected words left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_block_lock.md
RX_BLOCK_LOCK -- requirements
Module: rx_block_lock

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64: consecutive valid sync headers required to acquire lock.
REQ-002 SHALL have parameter GOOD_WIN, default 1024: header window length while locked.
REQ-003 SHALL have parameter BAD_MAX, default 16: invalid headers within one window that force lock loss.
REQ-004 SHALL have parameter SLIP_WAIT, default 4: valid header cycles ignored after each bitslip.
REQ-005 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rx_header  input  2  sync header of the current 66-bit block from the gearbox.
REQ-008 SHALL have port rx_header_valid  input  1  rx_header qualifier; only one header is sampled per high cycle.
REQ-009 SHALL have port block_lock  output  1  registered lock status; gates the 64-bit descrambler input.
REQ-010 SHALL have port bitslip  output  1  registered single-cycle request to the gearbox to shift alignment by one bit.
REQ-011 SHALL have port lock_loss_cnt  output  8  saturating count of LOCKED-to-unlocked transitions.

Function
REQ-012 A header SHALL be good when it equals 2'b01 or 2'b10, and bad when it equals 2'b00 or 2'b11.
REQ-013 The FSM SHALL have three states: UNLOCKED, LOCKED, and SLIP_HOLD. It SHALL also keep the counters sh_cnt, bad_cnt, and wait_cnt.
REQ-014 When rx_header_valid=0, no counter or state SHALL change, and bitslip SHALL be 0 in the following cycle.
REQ-015 In UNLOCKED, a good header SHALL increment sh_cnt.
REQ-016 In UNLOCKED, when the LOCK_CNT-th consecutive good header is sampled, the block SHALL set block_lock=1 on the next edge, clear the counters, and enter LOCKED.
REQ-017 In UNLOCKED, a bad header SHALL pulse bitslip=1 for exactly one cycle after the edge, clear sh_cnt, and enter SLIP_HOLD with wait_cnt=0.
REQ-018 In LOCKED, each sampled header SHALL increment sh_cnt, and each bad header SHALL also increment bad_cnt.
REQ-019 In LOCKED, when bad_cnt reaches BAD_MAX, the block SHALL:
- clear block_lock;
- pulse bitslip;
- increment lock_loss_cnt, saturating at 255 with no wrap;
- clear the counters;
- enter SLIP_HOLD.
REQ-020 In LOCKED, when sh_cnt reaches GOOD_WIN with bad_cnt<BAD_MAX, both counters SHALL clear and the block SHALL stay LOCKED; the next window then starts at 0.
REQ-021 When the BAD_MAX-th bad header is also the GOOD_WIN-th header, lock loss (REQ-019) SHALL take precedence.
REQ-022 In SLIP_HOLD, each valid header SHALL be ignored, whatever its value, and SHALL increment wait_cnt. After the SLIP_WAIT-th such header, the block SHALL enter UNLOCKED with counters cleared.
REQ-023 In SLIP_HOLD, block_lock SHALL be 0 and no further bitslip SHALL be issued.
REQ-024 bitslip SHALL never be high on two consecutive cycles.
REQ-025 Counters SHALL be sized by $clog2 of their parameter plus 1 and SHALL never wrap.

Reset
REQ-026 While rst=1, the block SHALL hold block_lock=0, bitslip=0, lock_loss_cnt=0, all counters=0, and state=UNLOCKED. This SHALL take effect asynchronously, without waiting for a CLK edge.
REQ-027 After rst is released, operation SHALL resume from UNLOCKED on the first sampled header.
REQ-028 rst asserted while LOCKED or SLIP_HOLD SHALL drop block_lock immediately and SHALL NOT increment lock_loss_cnt.

Verification
REQ-029 Scenario "reset": rst=1 with random headers -> block_lock=0, bitslip=0, lock_loss_cnt=0 throughout.
REQ-030 Scenario "acquire": 63 headers of 2'b01 -> block_lock=0; the 64th header (2'b10) -> block_lock=1 on the next cycle.
REQ-031 Scenario "slip": 10 good headers, then 2'b00 -> one bitslip pulse. Next, 4 headers of 2'b11 -> no bitslip and block_lock=0. Then 64 good headers -> block_lock=1.
REQ-032 Scenario "bad threshold": while locked, 15 bad headers in a 1024 window -> lock held. The 16th bad header in the same window -> block_lock=0, one bitslip pulse, lock_loss_cnt=1.
REQ-033 Scenario "window boundary": 15 bad headers in window 1, window 1 completes, then 15 bad headers in window 2 -> lock held. Separately, the 16th bad header arriving as header 1024 -> lock lost.
REQ-034 Scenario "reset and saturation":
- rst pulsed mid-LOCKED -> block_lock falls with no clock edge, and lock_loss_cnt=0.
- 300 forced lock losses -> lock_loss_cnt=255.
- rx_header_valid gaps inserted anywhere -> lock-acquire timing is unchanged when counted in valid headers.
